// File: rtl/mem_arbiter_pkg.sv
// Shared memory-unit definitions (function codes and widths from memory_unit.vh)
// plus the request payload type used by the pending slots.
`ifndef MEMORY_UNIT_VH
`define MEMORY_UNIT_VH
`define GET_CONTENTS      2'b01
`define SET_CONTENTS      2'b10
`define MEMORY_ADDR_WIDTH 12
`define MEMORY_DATA_WIDTH 36
`endif

package mem_arbiter_pkg;

   localparam int ADDR_W = `MEMORY_ADDR_WIDTH;
   localparam int DATA_W = `MEMORY_DATA_WIDTH;

   localparam logic [1:0] FUNC_GET = `GET_CONTENTS;
   localparam logic [1:0] FUNC_SET = `SET_CONTENTS;

   typedef struct packed {
      logic [1:0]        func;
      logic [ADDR_W-1:0] read_addr;
      logic [ADDR_W-1:0] write_addr;
      logic [DATA_W-1:0] write_data;
   } mem_req_t;

endpackage

// File: rtl/mem_req_slot.sv
// One-deep pending request slot for a single requester, with a sticky overrun
// flag raised when a strobe arrives while the slot is still occupied.
module mem_req_slot
   import mem_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              execute_i,
   input  logic [1:0]        func_i,
   input  logic [ADDR_W-1:0] read_addr_i,
   input  logic [ADDR_W-1:0] write_addr_i,
   input  logic [DATA_W-1:0] write_data_i,
   input  logic              complete_i,
   output logic              valid_o,
   output logic [1:0]        func_o,
   output logic [ADDR_W-1:0] read_addr_o,
   output logic [ADDR_W-1:0] write_addr_o,
   output logic [DATA_W-1:0] write_data_o,
   output logic              overrun_o
);

   mem_req_t req_q, req_d;
   logic     valid_q, valid_d;
   logic     overrun_q, overrun_d;

   // A strobe on the completing edge reuses the slot instead of overrunning.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      valid_d   = valid_q & ~complete_i;
      req_d     = req_q;
      overrun_d = overrun_q;
      if (execute_i) begin
         if (!valid_q || complete_i) begin
            valid_d = 1'b1;
            req_d   = '{func: func_i, read_addr: read_addr_i,
                        write_addr: write_addr_i, write_data: write_data_i};
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!rst) begin
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
      // NOTE: the payload is only ever read while valid_q is set, so it needs no reset.
      req_q <= req_d;
   end

   assign valid_o      = valid_q;
   assign func_o       = req_q.func;
   assign read_addr_o  = req_q.read_addr;
   assign write_addr_o = req_q.write_addr;
   assign write_data_o = req_q.write_data;
   assign overrun_o    = overrun_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-outstanding memory unit: alternating
// grants under contention, registered command outputs, one-cycle ready pulses.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int FIRST_PRIO = 0
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_execute,
   input  logic [1:0]        p0_func,
   input  logic [ADDR_W-1:0] p0_read_addr,
   input  logic [ADDR_W-1:0] p0_write_addr,
   input  logic [DATA_W-1:0] p0_write_data,
   output logic              p0_ready,
   output logic [DATA_W-1:0] p0_read_data,
   output logic              p0_overrun,
   input  logic              p1_execute,
   input  logic [1:0]        p1_func,
   input  logic [ADDR_W-1:0] p1_read_addr,
   input  logic [ADDR_W-1:0] p1_write_addr,
   input  logic [DATA_W-1:0] p1_write_data,
   output logic              p1_ready,
   output logic [DATA_W-1:0] p1_read_data,
   output logic              p1_overrun,
   output logic              mem_execute,
   output logic [1:0]        mem_func,
   output logic [ADDR_W-1:0] read_addr,
   output logic [ADDR_W-1:0] write_addr,
   output logic [DATA_W-1:0] write_data,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] read_data
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   // Reset value of last-grant is the port that must NOT win the first contention.
   localparam logic LAST_RST = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

   state_t            state_q, state_d;
   logic              grant_q, grant_d;
   logic              last_q, last_d;
   logic              mem_execute_q, mem_execute_d;
   logic [1:0]        mem_func_q, mem_func_d;
   logic [ADDR_W-1:0] read_addr_q, read_addr_d;
   logic [ADDR_W-1:0] write_addr_q, write_addr_d;
   logic [DATA_W-1:0] write_data_q, write_data_d;
   logic              p0_ready_q, p0_ready_d, p1_ready_q, p1_ready_d;
   logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;

   logic [1:0]        slot_valid;
   logic [1:0]        slot_done;
   logic [1:0]        slot_ovr;
   logic [1:0]        slot_func  [2];
   logic [ADDR_W-1:0] slot_raddr [2];
   logic [ADDR_W-1:0] slot_waddr [2];
   logic [DATA_W-1:0] slot_wdata [2];
   logic              pick;
   logic              op_done;

   mem_req_slot u_slot0 (
      .clk(clk), .rst(rst), .execute_i(p0_execute), .func_i(p0_func),
      .read_addr_i(p0_read_addr), .write_addr_i(p0_write_addr),
      .write_data_i(p0_write_data), .complete_i(slot_done[0]),
      .valid_o(slot_valid[0]), .func_o(slot_func[0]), .read_addr_o(slot_raddr[0]),
      .write_addr_o(slot_waddr[0]), .write_data_o(slot_wdata[0]), .overrun_o(slot_ovr[0])
   );

   mem_req_slot u_slot1 (
      .clk(clk), .rst(rst), .execute_i(p1_execute), .func_i(p1_func),
      .read_addr_i(p1_read_addr), .write_addr_i(p1_write_addr),
      .write_data_i(p1_write_data), .complete_i(slot_done[1]),
      .valid_o(slot_valid[1]), .func_o(slot_func[1]), .read_addr_o(slot_raddr[1]),
      .write_addr_o(slot_waddr[1]), .write_data_o(slot_wdata[1]), .overrun_o(slot_ovr[1])
   );

   // ISSUE honours mem_ready just like WAIT, which covers a zero-wait memory.
   assign op_done   = (state_q != S_IDLE) && mem_ready;
   assign slot_done = {op_done & grant_q, op_done & ~grant_q};
   assign pick      = (slot_valid == 2'b11) ? ~last_q : slot_valid[1];

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      last_d        = last_q;
      mem_execute_d = 1'b0;
      mem_func_d    = '0;
      read_addr_d   = read_addr_q;
      write_addr_d  = '0;
      write_data_d  = '0;
      p0_ready_d    = 1'b0;
      p1_ready_d    = 1'b0;
      p0_rdata_d    = p0_rdata_q;
      p1_rdata_d    = p1_rdata_q;
      case (state_q)
         S_IDLE: begin
            if (|slot_valid) begin
               grant_d       = pick;
               last_d        = pick;
               mem_execute_d = 1'b1;
               mem_func_d    = slot_func[pick];
               read_addr_d   = slot_raddr[pick];
               write_addr_d  = slot_waddr[pick];
               write_data_d  = slot_wdata[pick];
               state_d       = S_ISSUE;
            end
         end
         S_ISSUE, S_WAIT: begin
            if (mem_ready) begin
               if (grant_q) begin
                  p1_ready_d = 1'b1;
                  p1_rdata_d = read_data;
               end else begin
                  p0_ready_d = 1'b1;
                  p0_rdata_d = read_data;
               end
               state_d = S_IDLE;
            end else begin
               state_d = S_WAIT;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         grant_q       <= 1'b0;
         last_q        <= LAST_RST;
         mem_execute_q <= 1'b0;
         mem_func_q    <= '0;
         read_addr_q   <= '0;
         write_addr_q  <= '0;
         write_data_q  <= '0;
         p0_ready_q    <= 1'b0;
         p1_ready_q    <= 1'b0;
         p0_rdata_q    <= '0;
         p1_rdata_q    <= '0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         last_q        <= last_d;
         mem_execute_q <= mem_execute_d;
         mem_func_q    <= mem_func_d;
         read_addr_q   <= read_addr_d;
         write_addr_q  <= write_addr_d;
         write_data_q  <= write_data_d;
         p0_ready_q    <= p0_ready_d;
         p1_ready_q    <= p1_ready_d;
         p0_rdata_q    <= p0_rdata_d;
         p1_rdata_q    <= p1_rdata_d;
      end
   end

   assign mem_execute  = mem_execute_q;
   assign mem_func     = mem_func_q;
   assign read_addr    = read_addr_q;
   assign write_addr   = write_addr_q;
   assign write_data   = write_data_q;
   assign p0_ready     = p0_ready_q;
   assign p1_ready     = p1_ready_q;
   assign p0_read_data = p0_rdata_q;
   assign p1_read_data = p1_rdata_q;
   assign p0_overrun   = slot_ovr[0];
   assign p1_overrun   = slot_ovr[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-level reference model compared every
// cycle, a vector table for contention, directed corner cases, random traffic.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int FP = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic              p0_execute, p1_execute;
   logic [1:0]        p0_func, p1_func;
   logic [ADDR_W-1:0] p0_read_addr, p0_write_addr, p1_read_addr, p1_write_addr;
   logic [DATA_W-1:0] p0_write_data, p1_write_data;
   logic              p0_ready, p1_ready, p0_overrun, p1_overrun;
   logic [DATA_W-1:0] p0_read_data, p1_read_data;
   logic              mem_execute, mem_ready;
   logic [1:0]        mem_func;
   logic [ADDR_W-1:0] read_addr, write_addr;
   logic [DATA_W-1:0] write_data, read_data;

   mem_arbiter #(.FIRST_PRIO(FP)) dut (
      .clk(clk), .rst(rst),
      .p0_execute(p0_execute), .p0_func(p0_func), .p0_read_addr(p0_read_addr),
      .p0_write_addr(p0_write_addr), .p0_write_data(p0_write_data),
      .p0_ready(p0_ready), .p0_read_data(p0_read_data), .p0_overrun(p0_overrun),
      .p1_execute(p1_execute), .p1_func(p1_func), .p1_read_addr(p1_read_addr),
      .p1_write_addr(p1_write_addr), .p1_write_data(p1_write_data),
      .p1_ready(p1_ready), .p1_read_data(p1_read_data), .p1_overrun(p1_overrun),
      .mem_execute(mem_execute), .mem_func(mem_func), .read_addr(read_addr),
      .write_addr(write_addr), .write_data(write_data),
      .mem_ready(mem_ready), .read_data(read_data)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   typedef struct {
      logic              valid;
      logic [1:0]        func;
      logic [ADDR_W-1:0] ra;
      logic [ADDR_W-1:0] wa;
      logic [DATA_W-1:0] wd;
   } req_t;

   req_t              pend [2];
   logic              in_flight;
   int                owner, last_port;
   logic              m_exec;
   logic [1:0]        m_func;
   logic [ADDR_W-1:0] m_ra, m_wa;
   logic [DATA_W-1:0] m_wd;
   logic              m_rdy [2];
   logic [DATA_W-1:0] m_rd  [2];
   logic              m_ovr [2];

   always @(posedge clk) begin
      req_t in_req [2];
      logic ex [2];
      logic done;
      int   g;
      ex[0] = p0_execute;
      ex[1] = p1_execute;
      in_req[0] = '{1'b1, p0_func, p0_read_addr, p0_write_addr, p0_write_data};
      in_req[1] = '{1'b1, p1_func, p1_read_addr, p1_write_addr, p1_write_data};
      if (!rst) begin
         for (int n = 0; n < 2; n++) begin
            pend[n].valid = 1'b0;
            m_rdy[n] = 1'b0; m_rd[n] = '0; m_ovr[n] = 1'b0;
         end
         in_flight = 1'b0; owner = 0; last_port = 1 - FP;
         m_exec = 1'b0; m_func = '0; m_ra = '0; m_wa = '0; m_wd = '0;
      end else begin
         done = in_flight && mem_ready;
         m_exec = 1'b0; m_func = '0; m_wa = '0; m_wd = '0;
         m_rdy[0] = 1'b0; m_rdy[1] = 1'b0;
         if (done) begin
            m_rdy[owner] = 1'b1;
            m_rd[owner]  = read_data;
            in_flight    = 1'b0;
         end else if (!in_flight && (pend[0].valid || pend[1].valid)) begin
            if (pend[0].valid && pend[1].valid) g = 1 - last_port;
            else g = pend[1].valid ? 1 : 0;
            m_exec = 1'b1; m_func = pend[g].func; m_ra = pend[g].ra;
            m_wa = pend[g].wa; m_wd = pend[g].wd;
            in_flight = 1'b1; owner = g; last_port = g;
         end
         for (int n = 0; n < 2; n++) begin
            if (done && owner == n) pend[n].valid = 1'b0;
            if (ex[n]) begin
               if (!pend[n].valid) pend[n] = in_req[n];
               else m_ovr[n] = 1'b1;
            end
         end
      end
      #1;
      check("mdl_mem_execute", 64'(mem_execute), 64'(m_exec));
      check("mdl_mem_func", 64'(mem_func), 64'(m_func));
      check("mdl_read_addr", 64'(read_addr), 64'(m_ra));
      check("mdl_write_addr", 64'(write_addr), 64'(m_wa));
      check("mdl_write_data", 64'(write_data), 64'(m_wd));
      check("mdl_p0_ready", 64'(p0_ready), 64'(m_rdy[0]));
      check("mdl_p1_ready", 64'(p1_ready), 64'(m_rdy[1]));
      check("mdl_p0_read_data", 64'(p0_read_data), 64'(m_rd[0]));
      check("mdl_p1_read_data", 64'(p1_read_data), 64'(m_rd[1]));
      check("mdl_p0_overrun", 64'(p0_overrun), 64'(m_ovr[0]));
      check("mdl_p1_overrun", 64'(p1_overrun), 64'(m_ovr[1]));
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle_inputs();
      p0_execute = 1'b0; p1_execute = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic set_p0(input logic [1:0] f, input logic [ADDR_W-1:0] ra,
                         input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
      p0_execute = 1'b1; p0_func = f; p0_read_addr = ra; p0_write_addr = wa; p0_write_data = wd;
   endtask

   task automatic set_p1(input logic [1:0] f, input logic [ADDR_W-1:0] ra,
                         input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
      p1_execute = 1'b1; p1_func = f; p1_read_addr = ra; p1_write_addr = wa; p1_write_data = wd;
   endtask

   typedef struct {
      logic              p0e;
      logic [ADDR_W-1:0] p0a;
      logic              p1e;
      logic [ADDR_W-1:0] p1a;
      logic              mr;
      logic [DATA_W-1:0] rd;
      logic              e_exec;
      logic [ADDR_W-1:0] e_ra;
      logic              e_r0;
      logic              e_r1;
      logic [DATA_W-1:0] e_d0;
      logic [DATA_W-1:0] e_d1;
   } vec_t;

   vec_t vecs [8];
   int   grants [$];
   int   n_exec;
   int   n_rdy;

   initial begin
      rst = 1'b0;
      idle_inputs();
      p0_func = '0; p0_read_addr = '0; p0_write_addr = '0; p0_write_data = '0;
      p1_func = '0; p1_read_addr = '0; p1_write_addr = '0; p1_write_data = '0;
      read_data = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // Contention after reset: p0 served first, then p1; stray mem_ready in IDLE ignored.
      vecs[0] = '{1, 12'h030, 1, 12'h040, 0, 36'h0,   0, 12'h000, 0, 0, 36'h0,   36'h0};
      vecs[1] = '{0, 12'h000, 0, 12'h000, 0, 36'h0,   1, 12'h030, 0, 0, 36'h0,   36'h0};
      vecs[2] = '{0, 12'h000, 0, 12'h000, 0, 36'h0,   0, 12'h030, 0, 0, 36'h0,   36'h0};
      vecs[3] = '{0, 12'h000, 0, 12'h000, 1, 36'h111, 0, 12'h030, 1, 0, 36'h111, 36'h0};
      vecs[4] = '{0, 12'h000, 0, 12'h000, 0, 36'h0,   1, 12'h040, 0, 0, 36'h111, 36'h0};
      vecs[5] = '{0, 12'h000, 0, 12'h000, 1, 36'h222, 0, 12'h040, 0, 1, 36'h111, 36'h222};
      vecs[6] = '{0, 12'h000, 0, 12'h000, 0, 36'h0,   0, 12'h040, 0, 0, 36'h111, 36'h222};
      vecs[7] = '{0, 12'h000, 0, 12'h000, 1, 36'h333, 0, 12'h040, 0, 0, 36'h111, 36'h222};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         p0_execute = vecs[i].p0e; p0_func = FUNC_GET; p0_read_addr = vecs[i].p0a;
         p1_execute = vecs[i].p1e; p1_func = FUNC_GET; p1_read_addr = vecs[i].p1a;
         mem_ready = vecs[i].mr; read_data = vecs[i].rd;
         @(posedge clk);
         #2;
         check($sformatf("vec%0d_mem_execute", i), 64'(mem_execute), 64'(vecs[i].e_exec));
         check($sformatf("vec%0d_read_addr", i), 64'(read_addr), 64'(vecs[i].e_ra));
         check($sformatf("vec%0d_p0_ready", i), 64'(p0_ready), 64'(vecs[i].e_r0));
         check($sformatf("vec%0d_p1_ready", i), 64'(p1_ready), 64'(vecs[i].e_r1));
         check($sformatf("vec%0d_p0_read_data", i), 64'(p0_read_data), 64'(vecs[i].e_d0));
         check($sformatf("vec%0d_p1_read_data", i), 64'(p1_read_data), 64'(vecs[i].e_d1));
      end

      // Single read with a 3-cycle memory, also checking reset values and latency.
      do_reset();
      check("rst_p0_read_data", 64'(p0_read_data), 64'h0);
      check("rst_read_addr", 64'(read_addr), 64'h0);
      @(negedge clk);
      set_p0(FUNC_GET, 12'h010, 12'h000, 36'h0);
      @(negedge clk);
      p0_execute = 1'b0;
      check("sr_not_yet", 64'(mem_execute), 64'h0);
      @(negedge clk);
      check("sr_exec", 64'(mem_execute), 64'h1);
      check("sr_read_addr", 64'(read_addr), 64'h010);
      n_exec = 0;
      repeat (2) begin
         @(negedge clk);
         n_exec += int'(mem_execute) + int'(p1_ready) + int'(p0_ready);
      end
      mem_ready = 1'b1; read_data = 36'h5_0001_0002;
      @(negedge clk);
      mem_ready = 1'b0; read_data = '0;
      check("sr_no_extra_activity", 64'(n_exec), 64'h0);
      check("sr_p0_ready", 64'(p0_ready), 64'h1);
      check("sr_p1_ready", 64'(p1_ready), 64'h0);
      check("sr_p0_read_data", 64'(p0_read_data), 64'h5_0001_0002);
      @(negedge clk);
      check("sr_ready_one_cycle", 64'(p0_ready), 64'h0);
      check("sr_read_data_hold", 64'(p0_read_data), 64'h5_0001_0002);

      // Overrun: p1 strobes twice more while its first request is outstanding.
      do_reset();
      @(negedge clk);
      set_p1(FUNC_GET, 12'h050, 12'h000, 36'h0);
      @(negedge clk);
      p1_read_addr = 12'h060;
      @(negedge clk);
      p1_read_addr = 12'h070;
      @(negedge clk);
      p1_execute = 1'b0;
      check("ovr_p1_overrun", 64'(p1_overrun), 64'h1);
      check("ovr_p0_overrun", 64'(p0_overrun), 64'h0);
      check("ovr_read_addr", 64'(read_addr), 64'h050);
      mem_ready = 1'b1; read_data = 36'h77;
      @(negedge clk);
      mem_ready = 1'b0;
      check("ovr_p1_ready", 64'(p1_ready), 64'h1);
      n_exec = 0;
      repeat (4) begin
         @(negedge clk);
         n_exec += int'(mem_execute);
      end
      check("ovr_only_first_issued", 64'(n_exec), 64'h0);
      check("ovr_sticky", 64'(p1_overrun), 64'h1);

      // Write against a zero-wait memory (mem_ready tied high).
      do_reset();
      mem_ready = 1'b1; read_data = 36'h0;
      @(negedge clk);
      set_p1(FUNC_SET, 12'h000, 12'h020, 36'hA);
      @(negedge clk);
      p1_execute = 1'b0;
      @(negedge clk);
      check("wr_exec", 64'(mem_execute), 64'h1);
      check("wr_func", 64'(mem_func), 64'(FUNC_SET));
      check("wr_write_addr", 64'(write_addr), 64'h020);
      check("wr_write_data", 64'(write_data), 64'hA);
      check("wr_ready_not_yet", 64'(p1_ready), 64'h0);
      @(negedge clk);
      check("wr_p1_ready", 64'(p1_ready), 64'h1);
      check("wr_exec_drop", 64'(mem_execute), 64'h0);
      check("wr_write_addr_clr", 64'(write_addr), 64'h0);
      mem_ready = 1'b0;

      // Reset during WAIT, then a late mem_ready, then a normal request.
      do_reset();
      @(negedge clk);
      set_p0(FUNC_GET, 12'h011, 12'h000, 36'h0);
      @(negedge clk);
      p0_execute = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      mem_ready = 1'b1; read_data = 36'h123;
      @(negedge clk);
      mem_ready = 1'b0;
      check("rw_p0_ready", 64'(p0_ready), 64'h0);
      check("rw_p1_ready", 64'(p1_ready), 64'h0);
      check("rw_outputs_zero", 64'({mem_execute, mem_func, read_addr, write_addr,
                                     p0_overrun, p1_overrun}), 64'h0);
      check("rw_read_data_zero", 64'(p0_read_data | p1_read_data | write_data), 64'h0);
      set_p0(FUNC_GET, 12'h012, 12'h000, 36'h0);
      @(negedge clk);
      p0_execute = 1'b0;
      @(negedge clk);
      check("rw_next_exec", 64'(mem_execute), 64'h1);
      mem_ready = 1'b1; read_data = 36'h456;
      @(negedge clk);
      mem_ready = 1'b0;
      check("rw_next_ready", 64'(p0_ready), 64'h1);
      check("rw_next_data", 64'(p0_read_data), 64'h456);

      // Fairness: both ports re-request on every ready; expect 0,1,0,1,...
      do_reset();
      @(negedge clk);
      set_p0(FUNC_GET, 12'h100, 12'h000, 36'h0);
      set_p1(FUNC_GET, 12'h200, 12'h000, 36'h0);
      mem_ready = 1'b1; read_data = 36'h9;
      grants.delete();
      for (int cyc = 0; cyc < 100 && grants.size() < 8; cyc++) begin
         @(negedge clk);
         if (mem_execute) grants.push_back((read_addr == 12'h200) ? 1 : 0);
         p0_execute = p0_ready;
         p1_execute = p1_ready;
      end
      idle_inputs();
      check("fair_grant_count", 64'(grants.size()), 64'd8);
      foreach (grants[k]) check($sformatf("fair_grant%0d", k), 64'(grants[k]), 64'(k % 2));

      // Random traffic against the reference model, with occasional resets.
      do_reset();
      n_rdy = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 299) != 0);
         p0_execute = ($urandom_range(0, 3) == 0);
         p0_func = $urandom_range(0, 1) ? FUNC_GET : FUNC_SET;
         p0_read_addr = ADDR_W'($urandom); p0_write_addr = ADDR_W'($urandom);
         p0_write_data = DATA_W'({$urandom, $urandom});
         p1_execute = ($urandom_range(0, 3) == 0);
         p1_func = $urandom_range(0, 1) ? FUNC_GET : FUNC_SET;
         p1_read_addr = ADDR_W'($urandom); p1_write_addr = ADDR_W'($urandom);
         p1_write_data = DATA_W'({$urandom, $urandom});
         mem_ready = ($urandom_range(0, 2) == 0);
         read_data = DATA_W'({$urandom, $urandom});
         n_rdy += int'(p0_ready) + int'(p1_ready);
      end
      rst = 1'b1;
      idle_inputs();
      check("rand_traffic_completed", 64'(n_rdy > 50), 64'h1);
      repeat (4) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: FIRST_PRIO, default 0; port (0 or 1) that wins the first contended arbitration after reset.
REQ-002 clk  input  1  sole clock; all logic on posedge clk.
REQ-003 rst  input  1  reset; synchronous, active-low.
REQ-004 pN_execute  input  1  (N=0,1) one-cycle request strobe from requester N.
REQ-005 pN_func  input  2  memory function (`GET_CONTENTS / `SET_CONTENTS); sampled with pN_execute.
REQ-006 pN_read_addr  input  `memory_addr_width  read address; sampled with pN_execute.
REQ-007 pN_write_addr  input  `memory_addr_width  write address; sampled with pN_execute.
REQ-008 pN_write_data  input  `memory_data_width  write data; sampled with pN_execute.
REQ-009 pN_ready  output  1  one-cycle completion pulse to requester N.
REQ-010 pN_read_data  output  `memory_data_width  data returned to requester N; valid while pN_ready=1.
REQ-011 pN_overrun  output  1  sticky: a request from N was dropped.
REQ-012 mem_execute  output  1  one-cycle command strobe to the memory unit.
REQ-013 mem_func  output  2  function to the memory unit.
REQ-014 read_addr, write_addr  output  `memory_addr_width  addresses to the memory unit.
REQ-015 write_data  output  `memory_data_width  write data to the memory unit.
REQ-016 mem_ready  input  1  memory-unit completion; read_data valid in the same cycle.
REQ-017 read_data  input  `memory_data_width  memory-unit read data.

Function
REQ-018 Each port SHALL have a one-deep pending slot (valid, func, read_addr, write_addr, write_data), loaded on the edge on which pN_execute=1.
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT.
REQ-020 IDLE: if any slot is valid, the arbiter SHALL grant one, register the granted slot onto mem_func/read_addr/write_addr/write_data, set mem_execute=1 and go to ISSUE.
REQ-021 Minimum latency SHALL be pN_execute at edge t -> mem_execute high during cycle t+2.
REQ-022 ISSUE: mem_execute, mem_func, write_addr and write_data SHALL return to 0; read_addr SHALL hold; go to WAIT.
REQ-023 WAIT: when mem_ready=1, the arbiter SHALL capture read_data into the granted port's pN_read_data, pulse its pN_ready for exactly one cycle, clear its slot and go to IDLE.
REQ-024 ISSUE SHALL also honour mem_ready=1 exactly as WAIT does (zero-wait memory).
REQ-025 Arbitration: if one slot is valid, grant it; if both, grant the port not granted last; the first contention after reset grants FIRST_PRIO.
REQ-026 pN_execute with port N's slot valid and not completing that edge SHALL drop the request and set pN_overrun; the slot is unchanged.
REQ-027 pN_execute on the same edge that port N's slot completes SHALL load the new request (no overrun).
REQ-028 The arbiter SHALL keep one memory operation outstanding at a time; no new mem_execute until the previous mem_ready.
REQ-029 mem_ready in IDLE SHALL be ignored.
REQ-030 pN_read_data SHALL hold its last value between ready pulses.

Reset
REQ-031 When rst=0 at a clock edge, the arbiter SHALL enter IDLE, clear both slots, both ready pulses and both overrun flags, and set last-grant so FIRST_PRIO wins next.
REQ-032 All outputs SHALL reset to 0, including read_addr and pN_read_data.
REQ-033 Reset during ISSUE/WAIT SHALL abandon the outstanding operation; a late mem_ready after reset SHALL produce no pN_ready.

Structure
REQ-034 Function codes and widths SHALL come from the shared header memory_unit.vh (`GET_CONTENTS, `SET_CONTENTS, `memory_addr_width, `memory_data_width); FSM encodings stay local parameters.
REQ-035 The per-port pending slot SHALL be a sub-module, mem_req_slot, instantiated twice.

Verification
REQ-036 Single read: p0 GET_CONTENTS, addr 0x010, memory answers 3 cycles later with 0x5_0001_0002 -> one mem_execute with read_addr=0x010, one p0_ready with that data, p1_ready stays 0.
REQ-037 Contention: p0 and p1 strobe on the same edge after reset, FIRST_PRIO=0 -> memory sees p0 then p1, and p0_ready precedes p1_ready.
REQ-038 Fairness: both ports re-request immediately on each ready for 8 operations -> strictly alternating grants 0,1,0,1...
REQ-039 Overrun: p1 strobes twice while its first request waits -> p1_overrun=1, only the first request reaches memory.
REQ-040 Write plus zero-wait memory: p1 SET_CONTENTS to 0x020, data 0xA, with mem_ready tied high -> write_addr=0x020 and write_data=0xA during mem_execute, then p1_ready one cycle later.
REQ-041 Reset mid-WAIT: rst=0 one cycle, then mem_ready pulses -> no pN_ready, all outputs 0, and the next request proceeds normally.
